// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - vending machine shared types: FSM states, coin denominations, change width
// Shared by the change dispenser and the vending machine controller.
package vm_pkg;

  localparam int CHG_W = 4;
  typedef logic [CHG_W-1:0] chg_t;

  localparam chg_t DENOM1 = chg_t'(1);
  localparam chg_t DENOM2 = chg_t'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_WAIT_REL,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_SELECT) || (s == ST_REQ) || (s == ST_WAIT_REL);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - vending machine / hopper side signals of the change dispenser
// master drives change requests and hopper status; slave is the dispenser.
interface change_dispenser_if;

  vm_pkg::chg_t chg_in;
  logic         chg_load;
  logic         ack;
  logic         empty1;
  logic         empty2;
  logic         clr_fault;
  logic         ej1;
  logic         ej2;
  logic         busy;
  logic         done;
  logic         fault;
  vm_pkg::chg_t remaining;

  modport master (
    output chg_in, chg_load, ack, empty1, empty2, clr_fault,
    input  ej1, ej2, busy, done, fault, remaining
  );

  modport slave (
    input  chg_in, chg_load, ack, empty1, empty2, clr_fault,
    output ej1, ej2, busy, done, fault, remaining
  );

endinterface

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - counts REQ cycles without hopper ack
// o_expired flags the cycle whose increment would reach ACK_TIMEOUT.
module ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_en && (r_count == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin change dispenser FSM driving 1- and 2-unit hoppers
// Pays out latched change largest-coin-first, one hopper request at a time.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave io_bus
);

  state_t r_state, w_state_nxt;
  chg_t   r_remaining, w_rem_nxt;
  chg_t   r_denom, w_denom_nxt;
  logic   r_ej1, r_ej2, r_busy, r_done, r_fault;
  logic   w_tmr_clr, w_tmr_en, w_expired;

  assign w_tmr_en = (r_state == ST_REQ) && !io_bus.ack;

  ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_denom_nxt = r_denom;
    w_tmr_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.chg_load) begin
          if (io_bus.chg_in != '0) begin
            w_state_nxt = ST_SELECT;
            w_rem_nxt   = io_bus.chg_in;
          end else begin
            w_state_nxt = ST_DONE;
            w_rem_nxt   = '0;
          end
        end
      end
      ST_SELECT: begin
        // Empty flags only matter here; a request already issued is never withdrawn
        if (r_remaining == '0) begin
          w_state_nxt = ST_DONE;
        end else if ((r_remaining >= DENOM2) && !io_bus.empty2) begin
          w_denom_nxt = DENOM2;
          w_state_nxt = ST_REQ;
          w_tmr_clr   = 1'b1;
        end else if (!io_bus.empty1) begin
          w_denom_nxt = DENOM1;
          w_state_nxt = ST_REQ;
          w_tmr_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_REQ: begin
        if (io_bus.ack) begin
          w_rem_nxt   = r_remaining - r_denom;
          w_state_nxt = ST_WAIT_REL;
        end else if (w_expired) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_WAIT_REL: begin
        if (!io_bus.ack) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_DONE: begin
        w_rem_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        if (io_bus.clr_fault) begin
          w_rem_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_rem_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_denom     <= DENOM1;
      r_ej1       <= 1'b0;
      r_ej2       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_denom     <= w_denom_nxt;
      // Outputs decode the next state so they switch together with the state they describe
      r_ej1       <= (w_state_nxt == ST_REQ) && (w_denom_nxt == DENOM1);
      r_ej2       <= (w_state_nxt == ST_REQ) && (w_denom_nxt == DENOM2);
      r_busy      <= is_busy(w_state_nxt);
      r_done      <= (w_state_nxt == ST_DONE);
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  assign io_bus.ej1       = r_ej1;
  assign io_bus.ej2       = r_ej2;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.fault     = r_fault;
  assign io_bus.remaining = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
// Vector table, hand-written corner sequences and random transactions against a coin-level model.
module tb_change_dispenser;

  localparam int ACK_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int dly_list[16];
  int hold;
  int coins[$];
  int rems[$];
  int n_done, end_rem, ej_cyc;
  bit saw_fault, busy_seen, both_hi;

  int m_coins[$];
  int m_rems[$];
  bit m_fault;
  int m_rem;

  int n1, n2;

  typedef struct {
    int chg;
    bit e1;
    bit e2;
    int dly;
    int n2;
    int n1;
    bit flt;
    int rem;
    int ejc;
    bit bsy;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Coin-level view: largest coin the hoppers allow, a request with no ack inside the window faults
  function automatic void model(input int chg, input bit e1, input bit e2);
    int rem;
    int c;
    rem = chg;
    m_coins.delete();
    m_rems.delete();
    m_fault = 1'b0;
    for (int i = 0; i < 16 && rem > 0; i++) begin
      if (rem >= 2 && !e2) c = 2;
      else if (!e1) c = 1;
      else begin
        m_fault = 1'b1;
        break;
      end
      m_rems.push_back(rem);
      if (dly_list[i] >= ACK_TIMEOUT) begin
        m_fault = 1'b1;
        break;
      end
      m_coins.push_back(c);
      rem -= c;
    end
    m_rem = rem;
  endfunction

  // Loads change, plays the hopper (ack after dly_list[k] cycles, released after hold), records events
  task automatic run_txn(input int chg, input bit e1, input bit e2);
    int k = 0;
    int cnt = 0;
    int hcnt = 0;
    bit fin = 1'b0;
    bit req;
    coins.delete();
    rems.delete();
    n_done = 0;
    ej_cyc = 0;
    saw_fault = 1'b0;
    busy_seen = 1'b0;
    both_hi = 1'b0;
    bus.empty1 = e1;
    bus.empty2 = e2;
    bus.chg_in = 4'(chg);
    bus.chg_load = 1'b1;
    tick();
    bus.chg_load = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      req = bus.ej1 || bus.ej2;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.ej1 && bus.ej2) both_hi = 1'b1;
      if (req) ej_cyc++;
      if (bus.done) n_done++;
      if (bus.fault) begin
        saw_fault = 1'b1;
        fin = 1'b1;
      end else if (n_done > 0 && !bus.done) begin
        fin = 1'b1;
      end else begin
        if (req && !bus.ack) begin
          if (cnt == 0) rems.push_back(int'(bus.remaining));
          if (cnt == dly_list[k]) begin
            bus.ack = 1'b1;
            coins.push_back(bus.ej2 ? 2 : 1);
            if (k < 15) k++;
            cnt = 0;
            hcnt = 0;
          end else begin
            cnt++;
          end
        end else if (bus.ack && !req) begin
          if (hcnt >= hold) bus.ack = 1'b0;
          else hcnt++;
        end
        tick();
      end
    end
    chk("txn_terminated", int'(fin), 1);
    bus.ack = 1'b0;
    if (saw_fault) begin
      tick();
      tick();
      chk("fault_held", int'(bus.fault), 1);
      end_rem = int'(bus.remaining);
      bus.clr_fault = 1'b1;
      tick();
      bus.clr_fault = 1'b0;
      chk("clr_fault_flag", int'(bus.fault), 0);
      chk("clr_fault_rem", int'(bus.remaining), 0);
      chk("clr_fault_busy", int'(bus.busy), 0);
    end else begin
      end_rem = int'(bus.remaining);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg;
    bit e1, e2;

    vecs[0] = '{7,  0, 0, 2,  3, 1, 0, 0, 12,  1};
    vecs[1] = '{5,  0, 1, 2,  0, 5, 0, 0, 15,  1};
    vecs[2] = '{0,  0, 0, 0,  0, 0, 0, 0, 0,   0};
    vecs[3] = '{3,  0, 0, 15, 0, 0, 1, 3, 15,  1};
    vecs[4] = '{1,  1, 0, 0,  0, 0, 1, 1, 0,   1};
    vecs[5] = '{4,  0, 0, 0,  2, 0, 0, 0, 2,   1};
    vecs[6] = '{15, 0, 0, 14, 7, 1, 0, 0, 120, 1};
    vecs[7] = '{3,  1, 0, 1,  1, 0, 1, 1, 2,   1};
    vecs[8] = '{2,  0, 1, 0,  0, 2, 0, 0, 2,   1};
    vecs[9] = '{6,  1, 1, 0,  0, 0, 1, 6, 0,   1};

    rst = 1'b1;
    bus.chg_in = 4'd5;
    bus.chg_load = 1'b1;
    bus.ack = 1'b0;
    bus.empty1 = 1'b0;
    bus.empty2 = 1'b0;
    bus.clr_fault = 1'b0;
    hold = 0;
    tick();
    tick();
    chk("rst_ej1", int'(bus.ej1), 0);
    chk("rst_ej2", int'(bus.ej2), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_rem", int'(bus.remaining), 0);
    bus.chg_load = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_after_rst", int'(bus.busy), 0);

    foreach (vecs[i]) begin
      for (int j = 0; j < 16; j++) dly_list[j] = vecs[i].dly;
      hold = 0;
      run_txn(vecs[i].chg, vecs[i].e1, vecs[i].e2);
      n1 = 0;
      n2 = 0;
      foreach (coins[j]) begin
        if (coins[j] == 2) n2++;
        else n1++;
      end
      chk($sformatf("v%0d_n2", i), n2, vecs[i].n2);
      chk($sformatf("v%0d_n1", i), n1, vecs[i].n1);
      chk($sformatf("v%0d_fault", i), int'(saw_fault), int'(vecs[i].flt));
      chk($sformatf("v%0d_done", i), n_done, vecs[i].flt ? 0 : 1);
      chk($sformatf("v%0d_rem", i), end_rem, vecs[i].rem);
      chk($sformatf("v%0d_ejcyc", i), ej_cyc, vecs[i].ejc);
      chk($sformatf("v%0d_busy", i), int'(busy_seen), int'(vecs[i].bsy));
      chk($sformatf("v%0d_excl", i), int'(both_hi), 0);
    end

    // Latency, ignored load, flag change in REQ, single-cycle WAIT_REL, reset mid-dispense
    bus.empty1 = 1'b0;
    bus.empty2 = 1'b0;
    bus.ack = 1'b0;
    bus.chg_in = 4'd7;
    bus.chg_load = 1'b1;
    tick();
    bus.chg_load = 1'b0;
    chk("lat_sel_ej2", int'(bus.ej2), 0);
    chk("lat_sel_busy", int'(bus.busy), 1);
    chk("lat_sel_rem", int'(bus.remaining), 7);
    tick();
    chk("lat_req_ej2", int'(bus.ej2), 1);
    chk("lat_req_ej1", int'(bus.ej1), 0);
    bus.chg_in = 4'd9;
    bus.chg_load = 1'b1;
    bus.empty2 = 1'b1;
    tick();
    bus.chg_load = 1'b0;
    chk("busy_load_ignored", int'(bus.remaining), 7);
    chk("flag_in_req_kept", int'(bus.ej2), 1);
    bus.empty2 = 1'b0;
    bus.ack = 1'b1;
    tick();
    chk("ack_ej2_clr", int'(bus.ej2), 0);
    chk("ack_rem", int'(bus.remaining), 5);
    bus.ack = 1'b0;
    tick();
    chk("wait_rel_ej2", int'(bus.ej2), 0);
    tick();
    chk("wait_rel_one_cycle", int'(bus.ej2), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ej1", int'(bus.ej1), 0);
    chk("midrst_ej2", int'(bus.ej2), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_fault", int'(bus.fault), 0);
    chk("midrst_rem", int'(bus.remaining), 0);
    tick();
    chk("midrst_idle", int'(bus.busy), 0);

    for (int t = 0; t < 20; t++) begin
      chg = int'($urandom_range(0, 15));
      e1 = ($urandom_range(0, 4) == 0);
      e2 = ($urandom_range(0, 3) == 0);
      hold = int'($urandom_range(0, 2));
      for (int j = 0; j < 16; j++)
        dly_list[j] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(15, 16))
                                                   : int'($urandom_range(0, 3));
      model(chg, e1, e2);
      run_txn(chg, e1, e2);
      chk($sformatf("r%0d_ncoins", t), int'(coins.size()), int'(m_coins.size()));
      if (coins.size() == m_coins.size())
        foreach (coins[j]) chk($sformatf("r%0d_coin%0d", t, j), coins[j], m_coins[j]);
      chk($sformatf("r%0d_nreq", t), int'(rems.size()), int'(m_rems.size()));
      if (rems.size() == m_rems.size())
        foreach (rems[j]) chk($sformatf("r%0d_rem%0d", t, j), rems[j], m_rems[j]);
      chk($sformatf("r%0d_fault", t), int'(saw_fault), int'(m_fault));
      chk($sformatf("r%0d_done", t), n_done, m_fault ? 0 : 1);
      chk($sformatf("r%0d_endrem", t), end_rem, m_rem);
      chk($sformatf("r%0d_excl", t), int'(both_hi), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
